// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg -- shared definitions for the data-memory arbiter.
// Contents: FSM state encodings, requester identifiers and the width of
// the read-latency down-counter (wide enough for latencies 1..8).
package dmem_arb_pkg;

  // FSM state encodings
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef logic [1:0] arb_state_t;

  // Requester identifiers, also the encoding of the owner output
  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_DBG  = 1'b1;

  // Latency counter width
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_arb_grant.sv
// dmem_arb_grant -- winner selection between the core and debug requesters.
// Macro: DMEM_ARB_RR_EN selects round-robin (requester not granted last wins
// on contention); without it the core has fixed priority over debug.
// Ports:
//   c_req, d_req : requests from core / debug
//   last_grant   : identity of the requester granted most recently
//   any_req      : at least one request present
//   winner       : selected requester (OWNER_CORE / OWNER_DBG)
module dmem_arb_grant
  import dmem_arb_pkg::*;
(
  input  logic c_req,
  input  logic d_req,
  input  logic last_grant,
  output logic any_req,
  output logic winner
);

`ifdef DMEM_ARB_RR_EN
  // Round-robin: contention goes to whoever was not served last
  always_comb begin
    any_req = c_req | d_req;
    if (c_req && d_req) begin
      winner = ~last_grant;
    end else if (d_req) begin
      winner = OWNER_DBG;
    end else begin
      winner = OWNER_CORE;
    end
  end
`else
  // The pointer is meaningless under fixed priority
  logic unused_last;
  assign unused_last = last_grant;

  // Fixed priority: debug only wins when the core is silent
  always_comb begin
    any_req = c_req | d_req;
    if (c_req) begin
      winner = OWNER_CORE;
    end else if (d_req) begin
      winner = OWNER_DBG;
    end else begin
      winner = OWNER_CORE;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares one single-port data memory between the core
// load/store path and the debug/loader port, one transaction at a time.
// Macro: DMEM_ARB_RR_EN enables round-robin arbitration (default: core
// has fixed priority and debug may be starved).
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   c_* / d_* request side         : req, we, addr, wdata, be (held to gnt)
//   c_gnt, d_gnt                   : one-cycle pulse when issued to memory
//   c_rvalid/c_rdata, d_rvalid/... : read response to the owner only
//   m_req, m_we, m_addr, m_wdata, m_be : memory command, zero outside ISSUE
//   m_rdata                        : memory read data, MEM_LAT after issue
//   busy, owner                    : not idle / requester of current txn
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [DATA_W/8-1:0] c_be,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              owner
);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             any_req;
  logic             winner;

  dmem_arb_grant u_grant (
    .c_req      (c_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

`ifdef DMEM_ARB_RR_EN
  // Last-grant pointer; resetting to debug makes the core win first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWNER_DBG;
    end else if (state == S_IDLE && any_req) begin
      last_grant <= winner;
    end else begin
      last_grant <= last_grant;
    end
  end
`else
  assign last_grant = OWNER_DBG;
`endif

  // FSM and registered datapath; the memory command registers double as the
  // latched transaction fields while in ISSUE and are zeroed everywhere else
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      owner    <= OWNER_CORE;
      busy     <= 1'b0;
      c_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
    end else begin
      c_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state <= S_ISSUE;
            busy  <= 1'b1;
            owner <= winner;
            m_req <= 1'b1;
            // gnt is raised together with the command so it pulses in ISSUE
            if (winner == OWNER_DBG) begin
              d_gnt   <= 1'b1;
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_be    <= d_be;
            end else begin
              c_gnt   <= 1'b1;
              m_we    <= c_we;
              m_addr  <= c_addr;
              m_wdata <= c_wdata;
              m_be    <= c_be;
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (m_we) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_WAIT;
            busy  <= 1'b1;
            cnt   <= CNT_W'(MEM_LAT);
          end
        end
        S_WAIT: begin
          busy <= 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= S_RESP;
            // Response registers are updated only for the owner
            if (owner == OWNER_DBG) begin
              d_rvalid <= 1'b1;
              d_rdata  <= m_rdata;
            end else begin
              c_rvalid <= 1'b1;
              c_rdata  <= m_rdata;
            end
          end else begin
            state <= S_WAIT;
            cnt   <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the processor's single-port data memory. Shares the data memory between the core load/store path and a debug/loader port (program/data preload, register-file-independent memory inspection). Serialises one transaction at a time, drives the memory port, and returns read data after a fixed memory latency. Sits between the core's memory stage, the debug port and the data memory instance.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles, legal 1..8
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- c_req, d_req  in  1  core / debug request; held with fields stable until its gnt
- c_we, d_we  in  1  1 = write, 0 = read
- c_addr, d_addr  in  ADDR_W  byte address
- c_wdata, d_wdata  in  DATA_W  write data
- c_be, d_be  in  DATA_W/8  byte enables (writes only)
- c_gnt, d_gnt  out  1  one-cycle pulse: request issued to memory
- c_rvalid, d_rvalid  out  1  one-cycle pulse: read data valid
- c_rdata, d_rdata  out  DATA_W  read data, valid with rvalid
- m_req, m_we, m_addr, m_wdata, m_be  out  1/1/ADDR_W/DATA_W/DATA_W/8  memory command
- m_rdata  in  DATA_W  memory read data
- busy  out  1  state is not IDLE
- owner  out  1  0 = core, 1 = debug; requester of current transaction

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req, select winner, latch its we/addr/wdata/be and owner -> ISSUE; else stay.
- ISSUE: m_req=1 with latched fields; gnt pulse to owner. Write -> IDLE. Read -> WAIT, load latency counter with MEM_LAT.
- WAIT: counter decrements each cycle; in the cycle it reads 1, capture m_rdata into response register -> RESP.
- RESP: rvalid pulse and rdata to owner only; -> IDLE.
- Non-owner rvalid/gnt always 0; rdata of non-owner holds last value.
- m_* outputs are 0 in every state except ISSUE.
- Arbitration default (macro absent): fixed priority, core over debug. Debug can be starved; documented, not prevented.
- Address passed through unmodified; no alignment checks.
- Requester dropping req before gnt is a protocol violation; arbiter behaviour then undefined only for that transaction's data, FSM still returns to IDLE.

## Timing
- Reset: state IDLE, all gnt/rvalid/m_req/m_we/busy/owner = 0, m_addr/m_wdata/m_be/rdata registers = 0, RR pointer = debug-last.
- Memory samples command at the rising edge ending ISSUE; m_rdata valid in cycle ISSUE+MEM_LAT.
- Write: req seen in cycle T (IDLE) -> gnt in T+1; next arbitration T+2.
- Read: req in T -> gnt T+1 -> rvalid T+2+MEM_LAT; next arbitration T+3+MEM_LAT.
- Requests arriving while busy wait; they are evaluated in the next IDLE cycle.
- Simultaneous c_req and d_req in IDLE: resolved by arbitration rule, loser waits without gnt.
- Reset asserted mid-transaction: next edge forces reset values; in-flight read returns no rvalid.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin; 1-bit last-grant pointer updated on each grant; on contention the requester not granted last wins; pointer reset makes core win first contention.
- Undefined: fixed priority, core wins; no pointer register.

## Structure
- Shared package dmem_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), OWNER_CORE=0 / OWNER_DBG=1 constants, latency counter width (4).
- One sub-module: dmem_arb_grant, grant selection (fixed or round-robin) from two reqs plus pointer; FSM and datapath stay in dmem_arbiter.

## Test plan
- Core write addr 0x0, wdata 0x14, be 0xF -> c_gnt one cycle later, m_req/m_we high one cycle with those fields, no rvalid, busy low after 2 cycles.
- Core read 0x0 with MEM_LAT=1, memory returns 0x14 -> c_rvalid with c_rdata=0x14 exactly 3 cycles after req seen; d_rvalid stays 0.
- c_req and d_req asserted same cycle, both writes, held -> fixed: core gnt first, debug second; with DMEM_ARB_RR_EN and both held continuously for 4 transactions: core, debug, core, debug.
- Debug read while core write in ISSUE -> debug waits; d_gnt in cycle after write's IDLE arbitration; MEM_LAT=3 gives d_rvalid 5 cycles after its sampling.
- rst asserted during WAIT of a read -> next cycle all outputs at reset values, no rvalid ever for that read; subsequent core read completes normally.
- Back-to-back reads, MEM_LAT=8 -> counter wraps correctly, each rvalid 10 cycles after its sampling, data matches per-address memory model.
